// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle) with saturation on overflow.
// Optional leading-zero mask enabled by defining BIN2BCD_LZ_BLANK_EN; otherwise lz_mask is tied to 0.
module bin2bcd_seq #(
   parameter int IN_W   = 32,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow,
   output logic [DIGITS-1:0]     lz_mask,
   output logic [1:0]            o_dbg_state
);

   // Handshake: start is taken on any rising edge where the FSM is in IDLE or DONE;
   // done pulses for exactly one cycle, and the result ports hold until the next pulse.
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [IN_W-1:0]    r_operand;
   logic [BCD_W-1:0]   r_scratch;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;
   logic [BCD_W-1:0]   w_adj;
   logic [BCD_W-1:0]   w_result;
   logic [DIGITS-1:0]  w_lz;
   logic               w_accept;

   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_SHIFT;
         S_SHIFT: if (r_cnt == CNT_W'(1)) w_next_state = S_DONE;
         S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state == S_SHIFT);
      o_dbg_state = r_state;
   end

   // Pre-shift correction: any digit >= 5 would exceed 9 after doubling.
   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
   end

   assign w_result = r_ovf ? {DIGITS{4'h9}} : r_scratch;

   always_comb begin
      w_lz = '0;
`ifdef BIN2BCD_LZ_BLANK_EN
      begin : g_lz
         logic w_zero_above;
         w_zero_above = 1'b1;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (w_result[4*i +: 4] == 4'd0);
            w_lz[i]      = w_zero_above;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_operand <= '0;
         r_scratch <= '0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_operand <= bin_in;
         r_scratch <= '0;
         r_ovf     <= 1'b0;
         r_cnt     <= CNT_W'(IN_W);
      end else if (r_state == S_SHIFT) begin
         r_scratch <= {w_adj[BCD_W-2:0], r_operand[IN_W-1]};
         r_operand <= {r_operand[IN_W-2:0], 1'b0};
         r_cnt     <= r_cnt - 1'b1;
         if (w_adj[BCD_W-1]) r_ovf <= 1'b1;
      end
   end

   // Result registers load on the edge leaving DONE, so done lines up with fresh data.
   always_ff @(posedge clk) begin
      if (rst) begin
         done     <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
         lz_mask  <= '0;
      end else begin
         done <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            bcd_out  <= w_result;
            overflow <= r_ovf;
            lz_mask  <= w_lz;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (IN_W=32, DIGITS=4): vector table, corner sequences, random vs. arithmetic model.
module tb_bin2bcd_seq;
   localparam int IN_W   = 32;
   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] bin_in;
   logic        busy;
   logic        done;
   logic [15:0] bcd_out;
   logic        overflow;
   logic [3:0]  lz_mask;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] val;
      logic [15:0] bcd;
      logic        ovf;
      logic [3:0]  lz_on;
   } vec_t;

   bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bin_in     (bin_in),
      .busy       (busy),
      .done       (done),
      .bcd_out    (bcd_out),
      .overflow   (overflow),
      .lz_mask    (lz_mask),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] lz_expect(input logic [3:0] lz_on);
`ifdef BIN2BCD_LZ_BLANK_EN
      return lz_on;
`else
      return (lz_on & 4'b0000);
`endif
   endfunction

   // Decimal model: saturate, then peel digits off with division.
   function automatic void ref_model(input logic [31:0] v, output logic [15:0] bcd,
                                     output logic ovf, output logic [3:0] lz);
      longint x;
      longint p;
      x   = longint'(v);
      ovf = (x > 9999);
      if (ovf) x = 9999;
      bcd = '0;
      lz  = '0;
      p   = 1;
      for (int d = 0; d < DIGITS; d++) begin
         bcd[4*d +: 4] = 4'((x / p) % 10);
         if (d >= 1) lz[d] = ((x / p) == 0);
         p = p * 10;
      end
      lz = lz_expect(lz);
   endfunction

   // One conversion started at edge 0; optional extra start at poke_edge and rst at rst_edge.
   task automatic conv(input logic [31:0] v, input int poke_edge, input logic [31:0] poke_val,
                       input int rst_edge, output int done_edge, output int n_done,
                       output logic [15:0] d_bcd, output logic d_ovf, output logic [3:0] d_lz);
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      @(negedge clk);
      done_edge = -1;
      n_done    = 0;
      d_bcd     = '0;
      d_ovf     = 1'b0;
      d_lz      = '0;
      for (int k = 1; k <= 60; k++) begin
         start  = (k == poke_edge);
         bin_in = (k == poke_edge) ? poke_val : $urandom;
         rst    = (k == rst_edge);
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            n_done++;
            if (done_edge < 0) begin
               done_edge = k;
               d_bcd     = bcd_out;
               d_ovf     = overflow;
               d_lz      = lz_mask;
            end
         end
         if (rst_edge < 0 && k == IN_W - 1) check("busy_in_shift", {31'd0, busy}, 32'd1);
         if (rst_edge < 0 && k == IN_W)     check("busy_in_done", {31'd0, busy}, 32'd0);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic run_check(input string name, input logic [31:0] v, input logic [15:0] e_bcd,
                            input logic e_ovf, input logic [3:0] e_lz);
      int          de;
      int          nd;
      logic [15:0] b;
      logic        o;
      logic [3:0]  l;
      conv(v, -1, 32'd0, -1, de, nd, b, o, l);
      check({name, "_latency"}, de, IN_W + 1);
      check({name, "_pulses"}, nd, 1);
      check({name, "_bcd"}, {16'd0, b}, {16'd0, e_bcd});
      check({name, "_ovf"}, {31'd0, o}, {31'd0, e_ovf});
      check({name, "_lz"}, {28'd0, l}, {28'd0, e_lz});
      check({name, "_hold"}, {16'd0, bcd_out}, {16'd0, e_bcd});
   endtask

   initial begin
      vec_t        vecs[10];
      int          de;
      int          nd;
      logic [15:0] b;
      logic        o;
      logic [3:0]  l;
      logic [31:0] rv;
      logic [15:0] m_bcd;
      logic        m_ovf;
      logic [3:0]  m_lz;
      int          e1;
      int          e2;
      logic [15:0] b1;
      logic [15:0] b2;

      vecs[0] = '{32'd1234,       16'h1234, 1'b0, 4'b0000};
      vecs[1] = '{32'd9999,       16'h9999, 1'b0, 4'b0000};
      vecs[2] = '{32'd10000,      16'h9999, 1'b1, 4'b0000};
      vecs[3] = '{32'd0,          16'h0000, 1'b0, 4'b1110};
      vecs[4] = '{32'd42,         16'h0042, 1'b0, 4'b1100};
      vecs[5] = '{32'hFFFF_FFFF,  16'h9999, 1'b1, 4'b0000};
      vecs[6] = '{32'd1,          16'h0001, 1'b0, 4'b1110};
      vecs[7] = '{32'd10,         16'h0010, 1'b0, 4'b1100};
      vecs[8] = '{32'd500,        16'h0500, 1'b0, 4'b1000};
      vecs[9] = '{32'd9990,       16'h9990, 1'b0, 4'b0000};

      rst    = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_bcd", {16'd0, bcd_out}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_lz", {28'd0, lz_mask}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);

      // rst and start together: reset wins, FSM stays idle.
      start  = 1'b1;
      bin_in = 32'd77;
      @(posedge clk);
      @(negedge clk);
      check("prio_state", {30'd0, dbg_state}, 32'd0);
      check("prio_busy", {31'd0, busy}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].val, vecs[i].bcd, vecs[i].ovf,
                   lz_expect(vecs[i].lz_on));
      end

      // Second start mid-conversion is ignored.
      conv(32'd1234, 10, 32'd5, -1, de, nd, b, o, l);
      check("ign_latency", de, 33);
      check("ign_bcd", {16'd0, b}, 32'h1234);

      // Reset mid-conversion aborts without a done pulse.
      conv(32'd1234, -1, 32'd0, 12, de, nd, b, o, l);
      check("abort_pulses", nd, 0);
      check("abort_bcd", {16'd0, bcd_out}, 32'd0);
      check("abort_ovf", {31'd0, overflow}, 32'd0);
      check("abort_lz", {28'd0, lz_mask}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      run_check("after_abort", 32'd42, 16'h0042, 1'b0, lz_expect(4'b1100));

      // Start held high through DONE: back-to-back conversions of 7 then 8.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 32'd7;
      @(posedge clk);
      @(negedge clk);
      e1 = -1;
      e2 = -1;
      b1 = '0;
      b2 = '0;
      for (int k = 1; k <= 80; k++) begin
         start  = (k <= 33);
         bin_in = 32'd8;
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (e1 < 0) begin
               e1 = k;
               b1 = bcd_out;
            end else if (e2 < 0) begin
               e2 = k;
               b2 = bcd_out;
            end
         end
      end
      start = 1'b0;
      check("b2b_first_edge", e1, 33);
      check("b2b_gap", e2 - e1, IN_W + 1);
      check("b2b_first_bcd", {16'd0, b1}, 32'h0007);
      check("b2b_second_bcd", {16'd0, b2}, 32'h0008);

      for (int i = 0; i < 16; i++) begin
         rv = (i % 2 == 0) ? 32'($urandom_range(0, 9999)) : $urandom;
         ref_model(rv, m_bcd, m_ovf, m_lz);
         run_check($sformatf("rand%0d", i), rv, m_bcd, m_ovf, m_lz);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
